// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field values, line geometry and the responder state encoding.
package sysbus_pkg;

    localparam logic       READ           = 1'b1;
    localparam logic       WRITE          = 1'b0;
    localparam logic [3:0] MEMORY         = 4'b0001;
    localparam logic [3:0] MMIO           = 4'b0011;
    localparam int         LINE_BYTES     = 64;
    localparam int         BEATS_PER_LINE = 8;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WAIT,
        RESP
    } resp_state_e;

    // Word index within a line wraps modulo 8.
    function automatic logic [2:0] next_word(input logic [2:0] w);
        return w + 3'd1;
    endfunction

endpackage

// File: rtl/sysbus_line_ram.sv
// Line-organised backing store: LINES x 8 x 64-bit words, single port, one word per access,
// synchronous write and registered (1-cycle) read. Contents are never cleared.
module sysbus_line_ram #(
    parameter int LINES  = 1024,
    parameter int ADDR_W = $clog2(LINES) + 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic [63:0]       rdata_o
);

    logic [63:0] mem_q [LINES*8];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: one 64-byte line transaction at a time, 8-beat reads or writes.
// Optional macro SYSBUS_CRITICAL_WORD_FIRST_EN starts each line at word req[5:3] instead of word 0.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int          LINES      = 1024,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          RD_LATENCY = 4,
    parameter int          TAG_W      = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    output logic             reqack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack
);

    localparam int          IDX_W = $clog2(LINES);
    localparam int          RAM_W = IDX_W + 3;
    localparam logic [63:0] SPAN  = 64'(LINES) * 64'(LINE_BYTES);

    // Address-cycle decode straight from the bus.
    logic [63:0]      req_offset;
    logic             req_in_range;
    logic [IDX_W-1:0] req_line;
    logic [2:0]       req_start;

    assign req_offset   = req - BASE_ADDR;
    assign req_in_range = (req >= BASE_ADDR) && (req_offset < SPAN);
    assign req_line     = req_offset[IDX_W+5:6];
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    assign req_start    = req[5:3];
`else
    assign req_start    = 3'd0;
`endif

    resp_state_e      state_q, state_d;
    logic [IDX_W-1:0] line_q, line_d;
    logic             inrange_q, inrange_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       beat_q, beat_d;
    logic [3:0]       lat_q, lat_d;
    logic             reqack_q, reqack_d;
    logic             respcyc_q, respcyc_d;
    logic [63:0]      resp_q, resp_d;
    logic [TAG_W-1:0] resptag_q, resptag_d;

    logic             ram_we;
    logic [IDX_W-1:0] ram_line;
    logic [2:0]       ram_word;
    logic [63:0]      ram_rdata;
    logic [63:0]      rd_word;
    logic             is_read;

    assign is_read = (tag_q[TAG_W-1] == READ);
    assign rd_word = inrange_q ? ram_rdata : 64'h0;

    // ptr_q names the word the RAM output will hold next cycle; on every beat advance the RAM is
    // already pointed one further, so consecutive acknowledged beats need no bubble.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        inrange_d = inrange_q;
        tag_d     = tag_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        reqack_d  = 1'b0;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        ram_we    = 1'b0;
        ram_line  = line_q;
        ram_word  = ptr_q;

        case (state_q)
            IDLE: begin
                ram_line = req_line;
                ram_word = req_start;
                if (reqcyc) begin
                    line_d    = req_line;
                    inrange_d = req_in_range;
                    tag_d     = reqtag;
                    ptr_d     = req_start;
                    beat_d    = 3'd0;
                    reqack_d  = 1'b1;
                    if (reqtag[TAG_W-1] == READ) begin
                        state_d = WAIT;
                        lat_d   = 4'(RD_LATENCY);
                    end else begin
                        state_d = WDATA;
                    end
                end
            end

            WDATA: begin
                if (reqcyc) begin
                    ram_we   = inrange_q && !reset;
                    reqack_d = 1'b1;
                    ptr_d    = next_word(ptr_q);
                    beat_d   = beat_q + 3'd1;
                    if (beat_q == 3'(BEATS_PER_LINE - 1)) begin
                        state_d   = RESP;
                        respcyc_d = 1'b1;
                        resp_d    = 64'h0;
                        resptag_d = tag_q;
                    end
                end
            end

            WAIT: begin
                if (lat_q == 4'd0) begin
                    ram_word  = next_word(ptr_q);
                    ptr_d     = next_word(ptr_q);
                    beat_d    = 3'd0;
                    state_d   = RESP;
                    respcyc_d = 1'b1;
                    resp_d    = rd_word;
                    resptag_d = tag_q;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end

            RESP: begin
                if (respack) begin
                    if (!is_read || beat_q == 3'(BEATS_PER_LINE - 1)) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = 64'h0;
                        resptag_d = '0;
                    end else begin
                        ram_word = next_word(ptr_q);
                        ptr_d    = next_word(ptr_q);
                        beat_d   = beat_q + 3'd1;
                        resp_d   = rd_word;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= 3'd0;
            lat_q     <= 4'd0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= 64'h0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Transaction context is only meaningful after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        line_q    <= line_d;
        inrange_q <= inrange_d;
        tag_q     <= tag_d;
        ptr_q     <= ptr_d;
    end

    sysbus_line_ram #(
        .LINES  (LINES),
        .ADDR_W (RAM_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  ({ram_line, ram_word}),
        .wdata_i (req),
        .rdata_o (ram_rdata)
    );

    assign reqack  = reqack_q;
    assign respcyc = respcyc_q;
    assign resp    = resp_q;
    assign resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomised scoreboard bench for sysbus_mem_responder against a line-array reference model.
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;

    localparam int          LINES = 16;
    localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
    localparam int          RDL   = 4;
    localparam int          TW    = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqcyc;
    logic [63:0]   req;
    logic [TW-1:0] reqtag;
    logic          reqack;
    logic          respcyc;
    logic [63:0]   resp;
    logic [TW-1:0] resptag;
    logic          respack;

    always #5 clk = ~clk;

    sysbus_mem_responder #(
        .LINES      (LINES),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (RDL),
        .TAG_W      (TW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqcyc  (reqcyc),
        .req     (req),
        .reqtag  (reqtag),
        .reqack  (reqack),
        .respcyc (respcyc),
        .resp    (resp),
        .resptag (resptag),
        .respack (respack)
    );

    typedef struct {
        logic [63:0]   data;
        logic [TW-1:0] tag;
        int            beat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model [LINES*8];
    int          pool [5] = '{0, 1, 2, 3, 15};
    int          checks = 0;
    int          errors = 0;
    int          bp_mode = 0;
    int          mon_beat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int start_of(input logic [63:0] a);
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
        return int'(a[5:3]);
`else
        return 0;
`endif
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(LINES * 64));
    endfunction

    function automatic int line_of(input logic [63:0] a);
        return int'((a - BASE) / 64);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops one expectation per new beat, checks holds while stalled.
    initial begin : monitor
        bit          new_beat;
        bit          ack;
        logic [63:0] cur_exp;
        int          stall;
        exp_t        e;
        new_beat = 1'b1;
        cur_exp  = 64'h0;
        stall    = 0;
        respack  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                respack  = 1'b0;
                new_beat = 1'b1;
                continue;
            end
            if (respcyc) begin
                if (new_beat) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected no beat", resp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", resp, e.data);
                        chk("beat_tag", 64'(resptag), 64'(e.tag));
                        cur_exp  = e.data;
                        mon_beat = e.beat;
                        stall    = 0;
                    end
                end else begin
                    chk("beat_hold", resp, cur_exp);
                end
                case (bp_mode)
                    0: ack = 1'b1;
                    1: ack = ($urandom_range(0, 2) != 0);
                    2: begin
                        if ((mon_beat == 2 || mon_beat == 5) && stall < 3) begin
                            ack = 1'b0;
                            stall++;
                        end else begin
                            ack = 1'b1;
                        end
                    end
                    default: ack = (mon_beat < 4);
                endcase
                respack  = ack;
                new_beat = ack;
            end else begin
                respack  = 1'($urandom_range(0, 1));
                new_beat = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || respcyc) && n < 400) begin
            tick();
            n++;
        end
        chk("idle_reached", 64'(n >= 400), 64'd0);
        if (n >= 400) exp_q.delete();
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] id, input logic [3:0] typ,
                           input bit spur);
        logic [TW-1:0] tag;
        int            s, n;
        exp_t          e;
        tag = {READ, typ, id};
        s   = start_of(addr);
        for (int k = 0; k < 8; k++) begin
            e.data = in_range(addr) ? model[line_of(addr) * 8 + (s + k) % 8] : 64'h0;
            e.tag  = tag;
            e.beat = k;
            exp_q.push_back(e);
        end
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        tick();
        chk("rd_reqack", 64'(reqack), 64'd1);
        reqcyc = spur;
        req    = {$urandom, $urandom};
        reqtag = TW'($urandom);
        n = 0;
        do begin
            tick();
            n++;
            chk("rd_no_extra_ack", 64'(reqack), 64'd0);
        end while (!respcyc && n < 40);
        reqcyc = 1'b0;
        chk("rd_latency", 64'(n), 64'(RDL + 1));
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] d [8], input logic [7:0] id,
                            input int stall_at, input bit rnd_stall);
        logic [TW-1:0] tag;
        int            s, k;
        bit            prev, stalled;
        exp_t          e;
        tag    = {WRITE, MEMORY, id};
        s      = start_of(addr);
        e.data = 64'h0;
        e.tag  = tag;
        e.beat = 0;
        exp_q.push_back(e);
        reqcyc  = 1'b1;
        req     = addr;
        reqtag  = tag;
        prev    = 1'b1;
        stalled = 1'b0;
        k       = 0;
        while (k < 8) begin
            tick();
            chk("wr_reqack", 64'(reqack), 64'(prev));
            if ((k == stall_at && !stalled) || (rnd_stall && $urandom_range(0, 3) == 0)) begin
                stalled = 1'b1;
                reqcyc  = 1'b0;
                req     = {$urandom, $urandom};
                prev    = 1'b0;
            end else begin
                reqcyc = 1'b1;
                req    = d[k];
                reqtag = TW'($urandom);
                prev   = 1'b1;
                if (in_range(addr)) model[line_of(addr) * 8 + (s + k) % 8] = d[k];
                k++;
            end
        end
        tick();
        chk("wr_reqack_last", 64'(reqack), 64'd1);
        reqcyc = 1'b0;
        tick();
        chk("wr_reqack_end", 64'(reqack), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [63:0] d [8];
        int          n;
        reset  = 1'b1;
        reqcyc = 1'b0;
        req    = 64'h0;
        reqtag = '0;
        tick();
        tick();
        chk("rst_reqack", 64'(reqack), 64'd0);
        chk("rst_respcyc", 64'(respcyc), 64'd0);
        chk("rst_resp", resp, 64'h0);
        chk("rst_resptag", 64'(resptag), 64'd0);
        reset = 1'b0;
        tick();

        // Preload lines 0, 2, 3 and 15; line 2 holds A0..A7.
        for (int k = 0; k < 8; k++) d[k] = 64'hA0 + 64'(k);
        do_write(BASE + 64'h80, d, 8'h01, -1, 1'b0);
        wait_idle();
        foreach (pool[i]) begin
            if (pool[i] != 2 && pool[i] != 1) begin
                for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
                do_write(BASE + 64'(pool[i]) * 64, d, 8'h02, -1, 1'b0);
                wait_idle();
            end
        end

        do_read(BASE + 64'h80, 8'h5A, MEMORY, 1'b0);
        wait_idle();
        do_read(BASE + 64'h98, 8'h5B, MEMORY, 1'b1);
        wait_idle();

        bp_mode = 2;
        do_read(BASE + 64'h80, 8'h33, MMIO, 1'b0);
        wait_idle();
        bp_mode = 0;

        for (int k = 0; k < 8; k++) d[k] = 64'h10 + 64'(k);
        do_write(BASE + 64'h40, d, 8'h44, 4, 1'b0);
        wait_idle();
        do_read(BASE + 64'h40, 8'h45, MEMORY, 1'b0);
        wait_idle();

        do_read(BASE + 64'(LINES * 64), 8'h66, MEMORY, 1'b0);
        wait_idle();
        for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
        do_write(BASE + 64'(LINES * 64), d, 8'h67, -1, 1'b0);
        wait_idle();
        do_write(BASE - 64'd64, d, 8'h68, 2, 1'b0);
        wait_idle();
        do_read(BASE, 8'h69, MEMORY, 1'b0);
        wait_idle();
        do_read(BASE + 64'(15 * 64), 8'h6A, MEMORY, 1'b0);
        wait_idle();

        // Reset while beat 4 of a read is being held.
        bp_mode  = 3;
        mon_beat = -1;
        do_read(BASE + 64'h80, 8'h77, MEMORY, 1'b0);
        n = 0;
        while (!(respcyc && mon_beat == 4) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_beat4", 64'(n >= 50), 64'd0);
        reset = 1'b1;
        tick();
        chk("abort_respcyc", 64'(respcyc), 64'd0);
        chk("abort_resp", resp, 64'h0);
        chk("abort_resptag", 64'(resptag), 64'd0);
        chk("abort_reqack", 64'(reqack), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        bp_mode = 0;
        tick();
        do_read(BASE + 64'h80, 8'h78, MEMORY, 1'b0);
        wait_idle();

        // Random mix of reads and writes, in and out of range, with random back-pressure.
        bp_mode = 1;
        for (int t = 0; t < 40; t++) begin
            logic [63:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0)
                a = BASE + 64'(LINES * 64) + 64'($urandom_range(0, 4095));
            else if (r == 1)
                a = BASE - 64'($urandom_range(1, 4096));
            else
                a = BASE + 64'(pool[$urandom_range(0, 4)]) * 64 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                do_read(a, 8'($urandom), ($urandom_range(0, 1) == 1) ? MMIO : MEMORY,
                        1'($urandom_range(0, 1)));
            end else begin
                for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
                do_write(a, d, 8'($urandom), -1, 1'b1);
            end
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Responder (memory side) of the Sysbus request/response protocol that the core uses as initiator for instruction fetch.
- Accepts one 64-byte line request at a time, acknowledges it, then either returns 8 × 64-bit read beats or absorbs 8 write beats and returns a one-beat completion.
- Backed by an internal line-organised memory array.
- Serves as the bench-side and early-integration memory for core fetch and the future load/store path.

Parameters:
- LINES, 1024, number of 64-byte lines in the backing array; byte capacity = LINES*64.
- BASE_ADDR, 64'h0, physical address of line 0; must be 64-byte aligned.
- RD_LATENCY, 4, idle cycles between the reqack cycle and the first read beat; range 0..15.
- TAG_W, 13, width of reqtag/resptag: bit 12 = READ(1)/WRITE(0), bits 11:8 = type, bits 7:0 = id.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- reqcyc  in  1  request valid; address cycle, then write-data cycles for writes
- req  in  64  byte address on the address cycle; write data on data cycles
- reqtag  in  TAG_W  request tag; sampled on the address cycle only
- reqack  out  1  one-cycle acceptance of the address cycle and of each write-data beat
- respcyc  out  1  response beat valid
- resp  out  64  read data beat; zero on write completion
- resptag  out  TAG_W  echo of the captured reqtag for every response beat
- respack  in  1  initiator accepts the current response beat

Behaviour:
- All outputs are registered. Reset values: reqack=0, respcyc=0, resp=0, resptag=0, state=IDLE, beat counter=0. Memory contents are not cleared by reset.
- States: IDLE, WDATA, WAIT, RESP.
- IDLE, reqcyc=1:
  - Capture line = (req-BASE_ADDR)>>6, start word = req[5:3], and reqtag.
  - Drive reqack=1 on the next cycle, for exactly one cycle.
  - reqtag[12]=1 (read): go to WAIT with latency counter = RD_LATENCY.
  - reqtag[12]=0 (write): go to WDATA.
- WDATA:
  - Each cycle with reqcyc=1 writes req into word (start+k) mod 8 of the line and pulses reqack the next cycle.
  - Cycles with reqcyc=0 are stalls; nothing is written.
  - After the 8th beat, go to RESP with a single completion beat: resp=0, resptag=captured tag.
- WAIT: latency counter decrements each cycle; at 0, go to RESP. RD_LATENCY=0 means the first beat follows the reqack cycle directly.
- RESP, read:
  - Beat k (k=0..7) presents word (start+k) mod 8.
  - respcyc and resp hold stable until a cycle with respack=1; the beat advances on the following cycle.
  - After beat 7 is acknowledged, respcyc=0 and state returns to IDLE.
- RESP, write completion: one beat, held until respack; then IDLE.
- Only one transaction is outstanding at a time. reqcyc in any state other than IDLE (outside write data in WDATA) is ignored with no reqack; the initiator must hold it until acked.
- Addresses below BASE_ADDR or at/above BASE_ADDR+LINES*64: reads return all-zero beats with normal handshakes; writes are acked and discarded.
- Without the optional feature below, start word is forced to 0, so beats always run word 0..7 regardless of req[5:3].
- Reset asserted mid-transaction: return to IDLE the next cycle. Partially written lines keep the beats already written. No further beats for the aborted transaction.
- Line index arithmetic uses 64-bit subtract then shift; word index wraps modulo 8 (3-bit).

Optional Feature:
- Macro: SYSBUS_CRITICAL_WORD_FIRST_EN.
- Defined: start word = req[5:3], and beats wrap as described, so the requested word arrives first.
- Undefined: start word = 0 and req[5:3] is ignored.
- resptag and beat count are identical in both builds.

Decomposition:
- Shared package sysbus_pkg:
  - tag field constants READ=1, WRITE=0
  - type constants MEMORY=4'b0001, MMIO=4'b0011
  - LINE_BYTES=64, BEATS_PER_LINE=8
  - responder state enum
- One sub-module: sysbus_line_ram. Single-port synchronous array of LINES × 8 × 64-bit words with per-word write enable and 1-cycle read. The responder prefetches the next word to hide this latency.

Test Plan:
- Preload line 2 words 0..7 = 64'hA0..A7; read reqcyc req=BASE+0x80 tag={READ,MEMORY,8'h5A} -> reqack 1 cycle; after RD_LATENCY=4, beats A0..A7 with resptag echoing the tag.
- Critical-word-first: read req=BASE+0x98. With the feature defined -> beats A3,A4..A7,A0,A1,A2. With it undefined -> A0..A7.
- Back-pressure: read with respack low on beats 2 and 5 for 3 cycles each -> resp holds value; 8 beats total; no duplicates or drops.
- Write req=BASE+0x40, then 8 data beats 64'h10..17 with one stall cycle -> 8 data reqacks plus the address reqack; one completion beat resp=0; subsequent read returns 10..17.
- Out-of-range read at BASE+LINES*64 -> 8 zero beats. Out-of-range write is acked and leaves line 0 unchanged.
- Reset asserted during beat 4 of a read -> outputs 0 next cycle; state IDLE; a new read then completes normally.
